bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 13 +
 rtl/bus_arbiter_if.sv | 28 ++
 rtl/mux.sv | 19 +
 rtl/bus_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-requester bus arbiter: FSM state encodings
// and the default tenure length limit.
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN1 = 2'b01,
      OWN2 = 2'b10
   } state_t;

   localparam int MAX_HOLD_DEFAULT = 8;

endpackage

// File: rtl/bus_arbiter_if.sv
// Bus bundle between the two requesters and the arbiter.
// The master side drives requests and data; the slave side is the arbiter.
interface bus_arbiter_if;

   logic       req1;
   logic       req2;
   logic [7:0] data1;
   logic [7:0] data2;
   logic       last1;
   logic       last2;
   logic       gnt1;
   logic       gnt2;
   logic       select;
   logic [7:0] bus_out;
   logic       bus_valid;
   logic       timeout;

   modport master (
      output req1, req2, data1, data2, last1, last2,
      input  gnt1, gnt2, select, bus_out, bus_valid, timeout
   );

   modport slave (
      input  req1, req2, data1, data2, last1, last2,
      output gnt1, gnt2, select, bus_out, bus_valid, timeout
   );

endinterface

// File: rtl/mux.sv
// Existing 8-bit 2:1 data multiplexer: select=0 routes in1, select=1 routes in2.
module mux (
   input  logic [7:0] in1,
   input  logic [7:0] in2,
   input  logic       select,
   output logic [7:0] out
);

   // Pure steering of one of the two data words onto the output.
   always_comb begin
      out = 8'h00;
      if (select) begin
         out = in2;
      end else begin
         out = in1;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting one of two requesters a shared 8-bit bus.
// Define BUS_ARBITER_TIMEOUT_EN to bound each tenure to MAX_HOLD grant cycles.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
   input  logic           clk,
   input  logic           reset,
   bus_arbiter_if.slave   bus
);

   state_t state_r;
   state_t state_nx_s;
   logic   last_owner_r;   // 0: requester 1 owned last, 1: requester 2 owned last
   logic   gnt1_r;
   logic   gnt2_r;
   logic   valid_r;
   logic   select_r;
   logic   tmo1_s;
   logic   tmo2_s;
   logic   end1_s;
   logic   end2_s;

`ifdef BUS_ARBITER_TIMEOUT_EN
   localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

   logic [HOLD_W-1:0] hold_r;
   logic [HOLD_W-1:0] hold_nx_s;

   // Forced revoke on the last allowed cycle of a tenure that has not signalled its end.
   assign tmo1_s = (state_r == OWN1) && bus.req1 && !bus.last1 && (hold_r == HOLD_W'(MAX_HOLD));
   assign tmo2_s = (state_r == OWN2) && bus.req2 && !bus.last2 && (hold_r == HOLD_W'(MAX_HOLD));

   // Hold count is the number of grant cycles including the current one.
   always_comb begin
      hold_nx_s = {HOLD_W{1'b0}};
      if (state_nx_s == IDLE) begin
         hold_nx_s = {HOLD_W{1'b0}};
      end else if (state_nx_s != state_r) begin
         hold_nx_s = HOLD_W'(1);
      end else begin
         hold_nx_s = hold_r + HOLD_W'(1);
      end
   end

   // Tenure length counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_r <= {HOLD_W{1'b0}};
      end else begin
         hold_r <= hold_nx_s;
      end
   end
`else
   assign tmo1_s = 1'b0;
   assign tmo2_s = 1'b0;
`endif

   assign end1_s = bus.last1 || !bus.req1 || tmo1_s;
   assign end2_s = bus.last2 || !bus.req2 || tmo2_s;

   // Next-state logic; tenures hand over directly with no idle bubble.
   always_comb begin
      state_nx_s = IDLE;
      case (state_r)
         IDLE: begin
            if (bus.req1 && bus.req2) begin
               state_nx_s = last_owner_r ? OWN1 : OWN2;
            end else if (bus.req1) begin
               state_nx_s = OWN1;
            end else if (bus.req2) begin
               state_nx_s = OWN2;
            end else begin
               state_nx_s = IDLE;
            end
         end
         OWN1: begin
            if (end1_s) begin
               state_nx_s = bus.req2 ? OWN2 : IDLE;
            end else begin
               state_nx_s = OWN1;
            end
         end
         OWN2: begin
            if (end2_s) begin
               state_nx_s = bus.req1 ? OWN1 : IDLE;
            end else begin
               state_nx_s = OWN2;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // State plus registered grant, valid, select and round-robin owner.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         gnt1_r       <= 1'b0;
         gnt2_r       <= 1'b0;
         valid_r      <= 1'b0;
         select_r     <= 1'b0;
         last_owner_r <= 1'b1;
      end else begin
         state_r <= state_nx_s;
         gnt1_r  <= (state_nx_s == OWN1);
         gnt2_r  <= (state_nx_s == OWN2);
         valid_r <= (state_nx_s == OWN1) || (state_nx_s == OWN2);
         if (state_nx_s == OWN1) begin
            select_r     <= 1'b0;
            last_owner_r <= 1'b0;
         end else if (state_nx_s == OWN2) begin
            select_r     <= 1'b1;
            last_owner_r <= 1'b1;
         end else begin
            select_r     <= select_r;
            last_owner_r <= last_owner_r;
         end
      end
   end

   assign bus.gnt1      = gnt1_r;
   assign bus.gnt2      = gnt2_r;
   assign bus.bus_valid = valid_r;
   assign bus.select    = select_r;
   assign bus.timeout   = tmo1_s || tmo2_s;

   mux u_mux (
      .in1    (bus.data1),
      .in2    (bus.data2),
      .select (bus.select),
      .out    (bus.bus_out)
   );

endmodule
